// File: rtl/outbuffer_loader.sv
// Streams a byte source into the output buffer one bit per MCLK, MSB first, as a boot or user image.
// Optional LOADER_TIMEOUT_EN: abandon a load when WAITBYTE sees no byte for TIMEOUT_CYCLES cycles.
//
// state    | meaning
// IDLE     | waiting for LOADSTART
// WAITBYTE | BYTEREADY high, waiting for the next source byte
// SHIFT    | writing the captured byte, one bit per cycle
// DONE     | one-cycle LOADDONE pulse
module outbuffer_loader #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        BITWIDTH4,
  input  logic        LOADSTART,
  input  logic        LOADTYPE,
  input  logic        ABORT,
  input  logic [7:0]  BYTEIN,
  input  logic        BYTEVALID,
  output logic        BYTEREADY,
  output logic        nOUTBUFWRCLKEN,
  output logic [14:0] OUTBUFWRADDR,
  output logic        OUTBUFWRDATA,
  output logic        LOADBUSY,
  output logic        LOADDONE,
  output logic        LOADERR
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [12:0] remain_q, remain_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        emit;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // The address only advances when another bit follows, so the idle value is the last address written.
  assign emit = (state_q == S_SHIFT) && (remain_q != 13'd0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    byte_d   = byte_q;
    bitcnt_d = bitcnt_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (LOADSTART) begin
          if (LOADTYPE) begin
            addr_d   = BITWIDTH4 ? 15'd28672 : 15'd14336;
            remain_d = BITWIDTH4 ? 13'd2336 : 13'd1168;
          end else begin
            addr_d   = 15'd0;
            remain_d = BITWIDTH4 ? 13'd7708 : 13'd3854;
          end
          state_d = S_WAIT;
`ifdef LOADER_TIMEOUT_EN
          tmo_d = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      S_WAIT: begin
        if (BYTEVALID) begin
          byte_d   = BYTEIN;
          bitcnt_d = 3'd0;
          state_d  = S_SHIFT;
`ifdef LOADER_TIMEOUT_EN
        end else if (tmo_q == '0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
`endif
        end
      end
      S_SHIFT: begin
        if (emit) begin
          remain_d = remain_q - 13'd1;
          byte_d   = {byte_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (remain_q == 13'd1) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + 15'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = S_WAIT;
`ifdef LOADER_TIMEOUT_EN
              tmo_d = TW'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ABORT) begin
      state_d  = S_IDLE;
      addr_d   = addr_q;
      remain_d = 13'd0;
`ifdef LOADER_TIMEOUT_EN
      err_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      addr_q   <= 15'd0;
      remain_q <= 13'd0;
      byte_q   <= 8'd0;
      bitcnt_q <= 3'd0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      byte_q   <= byte_d;
      bitcnt_q <= bitcnt_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign BYTEREADY      = (state_q == S_WAIT);
  assign nOUTBUFWRCLKEN = ~emit;
  assign OUTBUFWRADDR   = addr_q;
  assign OUTBUFWRDATA   = emit & byte_q[7];
  assign LOADBUSY       = (state_q != S_IDLE);
  assign LOADDONE       = (state_q == S_DONE);
`ifdef LOADER_TIMEOUT_EN
  assign LOADERR        = err_q;
`else
  assign LOADERR        = 1'b0;
`endif

endmodule

// File: tb/tb_outbuffer_loader.sv
// Bench for outbuffer_loader: table of full loads checked bit-by-bit against a stream model,
// plus hand-written abort, timeout/wait and asynchronous reset sequences.
module tb_outbuffer_loader;

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic        BITWIDTH4, LOADSTART, LOADTYPE, ABORT, BYTEVALID;
  logic [7:0]  BYTEIN;
  logic        BYTEREADY, nOUTBUFWRCLKEN, OUTBUFWRDATA, LOADBUSY, LOADDONE, LOADERR;
  logic [14:0] OUTBUFWRADDR;

  outbuffer_loader #(.TIMEOUT_CYCLES(16)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .BITWIDTH4(BITWIDTH4), .LOADSTART(LOADSTART),
    .LOADTYPE(LOADTYPE), .ABORT(ABORT), .BYTEIN(BYTEIN), .BYTEVALID(BYTEVALID),
    .BYTEREADY(BYTEREADY), .nOUTBUFWRCLKEN(nOUTBUFWRCLKEN), .OUTBUFWRADDR(OUTBUFWRADDR),
    .OUTBUFWRDATA(OUTBUFWRDATA), .LOADBUSY(LOADBUSY), .LOADDONE(LOADDONE), .LOADERR(LOADERR)
  );

  always #5 MCLK = ~MCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [14:0] tk_addr[$];
  bit          tk_data[$];
  int          tk_cyc[$];
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, hs_cnt = 0;

  always @(negedge MCLK) begin
    cyc++;
    if (nRESET) begin
      if (!nOUTBUFWRCLKEN) begin
        tk_addr.push_back(OUTBUFWRADDR);
        tk_data.push_back(OUTBUFWRDATA);
        tk_cyc.push_back(cyc);
      end
      if (LOADDONE) begin done_cnt++; done_cyc = cyc; end
      if (LOADERR) err_cnt++;
      if (BYTEREADY && BYTEVALID) hs_cnt++;
    end
  end

  typedef struct {
    bit w4; bit ty; int mode; int ticks; int first; int last; int nbytes;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    tk_addr.delete(); tk_data.delete(); tk_cyc.delete();
    done_cnt = 0; err_cnt = 0; hs_cnt = 0;
  endtask

  task automatic start_load(input bit w4, input bit ty);
    @(posedge MCLK); #1;
    BITWIDTH4 = w4; LOADTYPE = ty; LOADSTART = 1'b1;
    @(posedge MCLK); #1;
    LOADSTART = 1'b0;
    BITWIDTH4 = 1'($urandom); LOADTYPE = 1'($urandom);
  endtask

  task automatic feed_byte(input logic [7:0] b, output bit ok);
    if ($urandom_range(0, 3) == 0) begin @(posedge MCLK); #1; end
    BYTEIN = b; BYTEVALID = 1'b1; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge MCLK);
      if (BYTEREADY) begin ok = 1'b1; break; end
    end
    @(posedge MCLK); #1;
    BYTEVALID = 1'b0; BYTEIN = 8'($urandom);
  endtask

  // Reference: bit k of the image goes to start+k and is bit (7 - k%8) of byte k/8.
  function automatic int stream_bad(input logic [7:0] bq[$], input int start, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b = bq[k / 8];
      if (int'(tk_addr[k]) != start + k || tk_data[k] != b[7 - (k % 8)]) bad++;
    end
    return bad;
  endfunction

  task automatic run_load(input bit w4, input bit ty, input int mode,
                          input int exp_ticks, input int exp_first, input int exp_last,
                          input int exp_bytes);
    logic [7:0] bq[$];
    int w, cnt, start, nby, sz, n;
    bit ok;
    w = w4 ? 4 : 2;
    cnt = (ty ? 584 : 1927) * w;
    start = ty ? 7168 * w : 0;
    nby = (cnt + 7) / 8;
    for (int i = 0; i < nby; i++)
      bq.push_back(mode == 0 ? (i == 0 ? 8'hA5 : 8'h00) : mode == 1 ? 8'hFF : 8'($urandom));
    clear_mon();
    start_load(w4, ty);
    for (int i = 0; i < nby; i++) begin
      feed_byte(bq[i], ok);
      if (!ok) begin chk("byte accept timeout", i, -1); break; end
    end
    for (int k = 0; k < 50 && done_cnt == 0; k++) begin @(negedge MCLK); #1; end
    repeat (3) @(negedge MCLK);
    #1;
    sz = tk_addr.size();
    chk("tick count", sz, exp_ticks);
    chk("bytes accepted", hs_cnt, exp_bytes);
    chk("first addr", sz > 0 ? int'(tk_addr[0]) : -1, exp_first);
    chk("last addr", sz > 0 ? int'(tk_addr[sz - 1]) : -1, exp_last);
    n = sz < cnt ? sz : cnt;
    chk("stream miscompares", stream_bad(bq, start, n), 0);
    chk("done pulses", done_cnt, 1);
    chk("done after last tick", sz > 0 ? done_cyc - tk_cyc[sz - 1] : -1, 1);
    chk("idle addr hold", OUTBUFWRADDR, exp_last);
    chk("idle busy", LOADBUSY, 0);
    chk("load err pulses", err_cnt, 0);
    if (mode == 0 && sz >= 8)
      chk("first 8 bits", {tk_data[0], tk_data[1], tk_data[2], tk_data[3],
                           tk_data[4], tk_data[5], tk_data[6], tk_data[7]}, 8'b10100101);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " nwrclken"}, nOUTBUFWRCLKEN, 1);
    chk({tag, " addr"}, OUTBUFWRADDR, 0);
    chk({tag, " data"}, OUTBUFWRDATA, 0);
    chk({tag, " ready"}, BYTEREADY, 0);
    chk({tag, " busy"}, LOADBUSY, 0);
    chk({tag, " done"}, LOADDONE, 0);
    chk({tag, " err"}, LOADERR, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abq[$];
    bit ok;
    int k;
    tbl[0] = '{w4: 0, ty: 1, mode: 0, ticks: 1168, first: 14336, last: 15503, nbytes: 146};
    tbl[1] = '{w4: 0, ty: 0, mode: 1, ticks: 3854, first: 0,     last: 3853,  nbytes: 482};
    tbl[2] = '{w4: 1, ty: 0, mode: 2, ticks: 7708, first: 0,     last: 7707,  nbytes: 964};
    tbl[3] = '{w4: 1, ty: 1, mode: 2, ticks: 2336, first: 28672, last: 31007, nbytes: 292};

    nRESET = 1'b0; BITWIDTH4 = 0; LOADSTART = 0; LOADTYPE = 0; ABORT = 0;
    BYTEVALID = 0; BYTEIN = 8'h00;
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(posedge MCLK);
    #1 nRESET = 1'b1;

    for (int i = 0; i < 4; i++)
      run_load(tbl[i].w4, tbl[i].ty, tbl[i].mode, tbl[i].ticks, tbl[i].first,
               tbl[i].last, tbl[i].nbytes);

    for (int r = 0; r < 2; r++) begin
      bit w4, ty;
      int w;
      w4 = 1'($urandom); ty = 1'($urandom); w = w4 ? 4 : 2;
      run_load(w4, ty, 2, (ty ? 584 : 1927) * w, ty ? 7168 * w : 0,
               (ty ? 7168 * w : 0) + (ty ? 584 : 1927) * w - 1, ((ty ? 584 : 1927) * w + 7) / 8);
    end

    // Abort on the third SHIFT cycle of byte 10, with LOADSTART waved mid-load.
    clear_mon();
    start_load(0, 0);
    for (int i = 0; i < 10; i++) abq.push_back(8'($urandom));
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 4) begin LOADSTART = 1; LOADTYPE = 1; BITWIDTH4 = 1; end
      else LOADSTART = 0;
      feed_byte(abq[i], ok);
      if (!ok) chk("abort feed timeout", i, -1);
    end
    @(posedge MCLK); @(posedge MCLK); #1;
    ABORT = 1'b1;
    @(negedge MCLK);
    chk("abort cycle tick", nOUTBUFWRCLKEN, 0);
    @(posedge MCLK); #1;
    ABORT = 1'b0;
    @(negedge MCLK);
    chk("abort busy", LOADBUSY, 0);
    chk("abort ready", BYTEREADY, 0);
    repeat (5) @(negedge MCLK);
    #1;
    chk("abort tick count", tk_addr.size(), 75);
    chk("abort stream", tk_addr.size() >= 75 ? stream_bad(abq, 0, 75) : -1, 0);
    chk("abort done", done_cnt, 0);

    // Abort wins over a handshake in the same cycle.
    clear_mon();
    start_load(1, 0);
    BYTEIN = 8'hFF; BYTEVALID = 1'b1; ABORT = 1'b1;
    @(posedge MCLK); #1;
    BYTEVALID = 1'b0; ABORT = 1'b0;
    repeat (4) @(negedge MCLK);
    #1;
    chk("abort+hs busy", LOADBUSY, 0);
    chk("abort+hs ticks", tk_addr.size(), 0);

    run_load(tbl[0].w4, tbl[0].ty, tbl[0].mode, tbl[0].ticks, tbl[0].first,
             tbl[0].last, tbl[0].nbytes);

    // Starved WAITBYTE.
    clear_mon();
    start_load(0, 0);
    for (k = 0; k < 40; k++) begin
      @(negedge MCLK); #1;
      if (LOADERR) break;
    end
`ifdef LOADER_TIMEOUT_EN
    chk("timeout cycle", k, 16);
    @(negedge MCLK); #1;
    chk("timeout err width", LOADERR, 0);
    chk("timeout idle", LOADBUSY, 0);
    chk("timeout done", done_cnt, 0);
`else
    chk("wait err", err_cnt, 0);
    chk("wait ready", BYTEREADY, 1);
    chk("wait busy", LOADBUSY, 1);
    @(posedge MCLK); #1 ABORT = 1'b1;
    @(posedge MCLK); #1 ABORT = 1'b0;
`endif

    // Asynchronous reset in the middle of SHIFT.
    clear_mon();
    start_load(0, 1);
    feed_byte(8'hC3, ok);
    #1;
    chk("pre-reset tick", nOUTBUFWRCLKEN, 0);
    nRESET = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    repeat (2) @(posedge MCLK);
    #1 nRESET = 1'b1;
    repeat (3) @(negedge MCLK);
    chk("post-reset busy", LOADBUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
